// File: rtl/sparc_ifu_dyser_stallctl.sv
// Stall-request generator for the DySER-owning thread: parks the thread while a
// recv targets an empty output port or a send targets a full input port.
module sparc_ifu_dyser_stallctl #(
    parameter int unsigned NPORT   = 8,
    parameter int unsigned PW      = 3,
    parameter int unsigned DYS_THR = 0,
    parameter int unsigned TMO_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       thr_e,
    input  logic             ifu_dyser_recv_e,
    input  logic             ifu_dyser_send_e,
    input  logic [PW-1:0]    ifu_dyser_port_e,
    input  logic             ifu_dyser_kill_e,
    input  logic [NPORT-1:0] dyser_outport_valid,
    input  logic [NPORT-1:0] dyser_inport_full,
    output logic             dyser_ifu_stallreq,
    output logic [PW-1:0]    dyser_stall_port,
    output logic             dyser_tmo_err
);

    localparam int unsigned PADN = 1 << PW;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        RECV_WAIT = 2'b01,
        SEND_WAIT = 2'b10
    } state_e;

    state_e           state_q;
    logic [PW-1:0]    port_q;
    logic [TMO_W-1:0] cnt_q;
    logic             stall_q;
    logic             tmo_q;

    logic [PADN-1:0]  valid_pad;
    logic [PADN-1:0]  full_pad;
    logic [PADN-1:0]  port_mask;
    logic             port_ok_c;
    logic             req_c;
    logic             recv_stall_c;
    logic             send_stall_c;
    logic             ready_c;

    // Pad port vectors to the full id space; ids beyond NPORT are masked off.
    always_comb begin
        port_mask = '0;
        for (int unsigned i = 0; i < PADN; i++) begin
            port_mask[i] = (i < NPORT);
        end
        valid_pad    = PADN'(dyser_outport_valid);
        full_pad     = PADN'(dyser_inport_full);
        port_ok_c    = port_mask[ifu_dyser_port_e];
        req_c        = thr_e[2'(DYS_THR)] & ~ifu_dyser_kill_e
                       & (ifu_dyser_recv_e | ifu_dyser_send_e);
        recv_stall_c = req_c & ifu_dyser_recv_e & port_ok_c
                       & ~valid_pad[ifu_dyser_port_e];
        send_stall_c = req_c & ~ifu_dyser_recv_e & ifu_dyser_send_e & port_ok_c
                       & full_pad[ifu_dyser_port_e];
        ready_c      = (state_q == RECV_WAIT) ? valid_pad[port_q] : ~full_pad[port_q];
    end

    // Stall FSM; requests arriving while parked are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            port_q  <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (recv_stall_c || send_stall_c) begin
                        state_q <= recv_stall_c ? RECV_WAIT : SEND_WAIT;
                        port_q  <= ifu_dyser_port_e;
                        cnt_q   <= '0;
                        stall_q <= 1'b1;
                    end
                end
                RECV_WAIT, SEND_WAIT: begin
                    if (ifu_dyser_kill_e || ready_c) begin
                        state_q <= IDLE;
                        stall_q <= 1'b0;
                    end else if (cnt_q == TMO_W'(TIMEOUT - 1)) begin
                        state_q <= IDLE;
                        stall_q <= 1'b0;
                        tmo_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + TMO_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign dyser_ifu_stallreq = stall_q;
    assign dyser_stall_port   = port_q;
    assign dyser_tmo_err      = tmo_q;

endmodule

// File: tb/tb_sparc_ifu_dyser_stallctl.sv
// Bench for sparc_ifu_dyser_stallctl: directed vector table, then random
// traffic checked against a transaction-level model of the stall rules.
module tb_sparc_ifu_dyser_stallctl;

    localparam int unsigned NPORT   = 6;
    localparam int unsigned PW      = 3;
    localparam int unsigned TMO_W   = 16;
    localparam int unsigned TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       thr_e;
    logic             recv_e;
    logic             send_e;
    logic [PW-1:0]    port_e;
    logic             kill_e;
    logic [NPORT-1:0] out_valid;
    logic [NPORT-1:0] in_full;
    logic             stallreq;
    logic [PW-1:0]    stall_port;
    logic             tmo_err;

    int n_chk = 0;
    int n_err = 0;

    sparc_ifu_dyser_stallctl #(
        .NPORT(NPORT), .PW(PW), .DYS_THR(0), .TMO_W(TMO_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .thr_e               (thr_e),
        .ifu_dyser_recv_e    (recv_e),
        .ifu_dyser_send_e    (send_e),
        .ifu_dyser_port_e    (port_e),
        .ifu_dyser_kill_e    (kill_e),
        .dyser_outport_valid (out_valid),
        .dyser_inport_full   (in_full),
        .dyser_ifu_stallreq  (stallreq),
        .dyser_stall_port    (stall_port),
        .dyser_tmo_err       (tmo_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic [3:0]       thr;
        logic             rc;
        logic             sd;
        logic [PW-1:0]    port;
        logic             kill;
        logic [NPORT-1:0] val;
        logic [NPORT-1:0] full;
        logic             e_st;
        logic [PW-1:0]    e_pt;
        logic             e_tmo;
    } vec_t;

    vec_t vecs[$];

    // Model: the thread is either running or parked on one (kind, port) wait.
    bit m_parked;
    bit m_is_recv;
    int m_port;
    int m_waited;
    bit m_tmo;

    function automatic vec_t v(logic rst, logic [3:0] thr, logic rc, logic sd, int port,
                               logic kill, logic [NPORT-1:0] val, logic [NPORT-1:0] full,
                               logic e_st, int e_pt, logic e_tmo);
        vec_t r;
        r.rst = rst; r.thr = thr; r.rc = rc; r.sd = sd; r.port = PW'(port);
        r.kill = kill; r.val = val; r.full = full;
        r.e_st = e_st; r.e_pt = PW'(e_pt); r.e_tmo = e_tmo;
        return r;
    endfunction

    task automatic drive(logic rst, logic [3:0] thr, logic rc, logic sd, logic [PW-1:0] p,
                         logic kill, logic [NPORT-1:0] val, logic [NPORT-1:0] full);
        reset = rst; thr_e = thr; recv_e = rc; send_e = sd; port_e = p;
        kill_e = kill; out_valid = val; in_full = full;
    endtask

    function automatic void model_step();
        bit rdy;
        int p;
        m_tmo = 1'b0;
        if (reset) begin
            m_parked = 1'b0; m_port = 0; m_waited = 0;
        end else if (!m_parked) begin
            p = int'(port_e);
            if (thr_e[0] && !kill_e && p < int'(NPORT)) begin
                if (recv_e) begin
                    if (!out_valid[p]) begin
                        m_parked = 1'b1; m_is_recv = 1'b1; m_port = p; m_waited = 0;
                    end
                end else if (send_e && in_full[p]) begin
                    m_parked = 1'b1; m_is_recv = 1'b0; m_port = p; m_waited = 0;
                end
            end
        end else begin
            rdy = m_is_recv ? out_valid[m_port] : !in_full[m_port];
            m_waited++;
            if (kill_e || rdy) begin
                m_parked = 1'b0;
            end else if (m_waited == int'(TIMEOUT)) begin
                m_parked = 1'b0;
                m_tmo = 1'b1;
            end
        end
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        drive(1'b1, 4'b0001, 1'b0, 1'b0, '0, 1'b0, '0, '0);

        // reset
        vecs.push_back(v(1, 4'h1, 0, 0, 0, 0, 6'h00, 6'h00, 0, 0, 0));
        // recv port 3 on empty port, data arrives after 5 stall cycles
        vecs.push_back(v(0, 4'h1, 1, 0, 3, 0, 6'h00, 6'h00, 1, 3, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h00, 6'h00, 1, 3, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h08, 6'h00, 0, 3, 0));
        // recv port 2 already valid: no stall, port holds
        vecs.push_back(v(0, 4'h1, 1, 0, 2, 0, 6'h04, 6'h00, 0, 3, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h04, 6'h00, 0, 3, 0));
        // kill in the same cycle valid rises
        vecs.push_back(v(0, 4'h1, 1, 0, 1, 0, 6'h00, 6'h00, 1, 1, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h00, 6'h00, 1, 1, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 1, 6'h02, 6'h00, 0, 1, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h02, 6'h00, 0, 1, 0));
        // send release then immediate recv: exactly one low cycle
        vecs.push_back(v(0, 4'h1, 0, 1, 4, 0, 6'h00, 6'h10, 1, 4, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h00, 6'h00, 0, 4, 0));
        vecs.push_back(v(0, 4'h1, 1, 0, 0, 0, 6'h00, 6'h00, 1, 0, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h01, 6'h00, 0, 0, 0));
        // recv+send together: recv wins (send readiness must not release)
        vecs.push_back(v(0, 4'h1, 1, 1, 5, 0, 6'h00, 6'h20, 1, 5, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h00, 6'h20, 1, 5, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h00, 6'h00, 1, 5, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h20, 6'h00, 0, 5, 0));
        // other thread request ignored
        vecs.push_back(v(0, 4'h2, 1, 0, 2, 0, 6'h00, 6'h00, 0, 5, 0));
        // port ids beyond NPORT never stall
        vecs.push_back(v(0, 4'h1, 1, 0, 6, 0, 6'h00, 6'h00, 0, 5, 0));
        vecs.push_back(v(0, 4'h1, 0, 1, 7, 0, 6'h00, 6'h3f, 0, 5, 0));
        // request while parked is ignored
        vecs.push_back(v(0, 4'h1, 1, 0, 3, 0, 6'h00, 6'h00, 1, 3, 0));
        vecs.push_back(v(0, 4'h1, 0, 1, 1, 0, 6'h00, 6'h3f, 1, 3, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h08, 6'h3f, 0, 3, 0));
        // send on permanently full port: 8 stall cycles then timeout pulse
        vecs.push_back(v(0, 4'h1, 0, 1, 5, 0, 6'h00, 6'h20, 1, 5, 0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h00, 6'h20, 1, 5, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h00, 6'h20, 0, 5, 1));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h00, 6'h20, 0, 5, 0));
        // reset mid-stall
        vecs.push_back(v(0, 4'h1, 1, 0, 2, 0, 6'h00, 6'h00, 1, 2, 0));
        vecs.push_back(v(1, 4'h1, 0, 0, 0, 0, 6'h00, 6'h00, 0, 0, 0));
        // ready on the final wait cycle beats timeout
        vecs.push_back(v(0, 4'h1, 1, 0, 1, 0, 6'h00, 6'h00, 1, 1, 0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h00, 6'h00, 1, 1, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h02, 6'h00, 0, 1, 0));
        // kill on the final wait cycle beats timeout
        vecs.push_back(v(0, 4'h1, 0, 1, 0, 0, 6'h00, 6'h01, 1, 0, 0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(v(0, 4'h1, 0, 0, 0, 0, 6'h00, 6'h01, 1, 0, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 1, 6'h00, 6'h01, 0, 0, 0));

        @(negedge clk);
        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].thr, vecs[k].rc, vecs[k].sd, vecs[k].port,
                  vecs[k].kill, vecs[k].val, vecs[k].full);
            cycle();
            chk($sformatf("vec%0d stallreq", k), 32'(stallreq), 32'(vecs[k].e_st));
            chk($sformatf("vec%0d port", k), 32'(stall_port), 32'(vecs[k].e_pt));
            chk($sformatf("vec%0d tmo", k), 32'(tmo_err), 32'(vecs[k].e_tmo));
        end

        // random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 7) ? 4'b0001 : 4'($urandom),
                  ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 9) < 3),
                  PW'($urandom_range(0, 7)),
                  ($urandom_range(0, 29) == 0),
                  NPORT'($urandom & $urandom & $urandom),
                  NPORT'($urandom | $urandom | $urandom));
            cycle();
            chk("rnd stallreq", 32'(stallreq), 32'(m_parked));
            chk("rnd port", 32'(stall_port), 32'(m_port));
            chk("rnd tmo", 32'(tmo_err), 32'(m_tmo));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
